fetch_unit: RTL

Multi-cycle instruction fetch stage for the SEQ Y86-64 core. Holds the architectural PC, reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake, and splits them into icode/ifun/rA/rB/valC/valP. The PC it holds is reloaded from the PC-update stage's `updated_pc` when the rest of the datapath has retired the current instruction. It also produces the processor status code (AOK/HLT/ADR/INS).

---
 rtl/fetch_imem_if.sv | 40 ++++
 rtl/fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_imem_if.sv
// ----------------------------------------------------------------------------
// fetch_imem_if
//
// Byte-wide instruction memory handshake between the fetch stage and the
// instruction memory.
//
// Signals:
//   req   fetch -> mem  byte read request, held until a cycle with ack=1
//   addr  fetch -> mem  64-bit byte address, stable while req is waiting
//   ack   mem -> fetch  the byte at addr is on data this cycle
//   data  mem -> fetch  read byte
//   err   mem -> fetch  qualified by ack: addr is not a valid address
//
// Modports:
//   master  used by the fetch unit (drives req/addr)
//   slave   used by the instruction memory (drives ack/data/err)
// ----------------------------------------------------------------------------
interface fetch_imem_if;
    logic        req;
    logic [63:0] addr;
    logic        ack;
    logic [7:0]  data;
    logic        err;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data,
        output err
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Multi-cycle fetch stage for the SEQ Y86-64 core. Holds the architectural PC,
// reads the instruction one byte per accepted handshake and splits it into
// icode/ifun/rA/rB/valC/valP. The PC is reloaded from the PC-update stage once
// the current instruction has been retired. Also produces the processor status
// code (1=AOK, 2=HLT, 3=ADR, 4=INS).
//
// Parameters:
//   RESET_PC        PC loaded on reset
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_pc_in         next PC from the PC-update stage
//   i_pc_load       retire strobe, only acted on once the instruction is done
//   imem            byte-wide instruction memory handshake (master side)
//   o_icode/o_ifun  decoded byte 0
//   o_ra/o_rb       register specifiers, 4'hF when the instruction has none
//   o_valc          little-endian constant, 0 when the instruction has none
//   o_valp          PC + instruction length (mod 2^64)
//   o_pc            current PC
//   o_instr_valid   decoded fields are complete and stable
//   o_stat          processor status code
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [63:0]         i_pc_in,
    input  logic                i_pc_load,
    fetch_imem_if.master        imem,
    output logic [3:0]          o_icode,
    output logic [3:0]          o_ifun,
    output logic [3:0]          o_ra,
    output logic [3:0]          o_rb,
    output logic [63:0]         o_valc,
    output logic [63:0]         o_valp,
    output logic [63:0]         o_pc,
    output logic                o_instr_valid,
    output logic [2:0]          o_stat
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DONE  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] REG_NONE = 4'hF;

    // Instruction length in bytes, selected by icode alone.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            default:                len = 4'd1;
        endcase
        return len;
    endfunction

    // Legal icode/ifun combinations for byte 0.
    function automatic logic byte0_valid(input logic [3:0] icode,
                                         input logic [3:0] ifun);
        logic ok;
        case (icode)
            4'h2, 4'h7: ok = (ifun <= 4'd6);
            4'h6:       ok = (ifun <= 4'd3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB:
                        ok = (ifun == 4'd0);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_pc;
    logic [3:0]  r_count;
    logic [3:0]  r_len;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic        r_valid;
    logic [2:0]  r_stat;

    logic [3:0]  w_len0;
    logic [3:0]  w_len;
    logic [3:0]  w_count_inc;
    logic        w_last;
    logic        w_bad0;
    logic [3:0]  w_icode_cur;
    logic        w_valc_byte;
    logic [2:0]  w_valc_idx;
    logic [63:0] w_addr;
    logic        w_beat;

    // Byte-level decode of the beat currently presented by the memory.
    always_comb begin
        w_len0      = instr_len(imem.data[7:4]);
        // Length is taken from byte 0 while it is arriving, from the
        // captured copy afterwards.
        w_len       = (r_count == 4'd0) ? w_len0 : r_len;
        w_count_inc = r_count + 4'd1;
        w_last      = (w_count_inc == w_len);
        w_bad0      = (r_count == 4'd0) &&
                      !byte0_valid(imem.data[7:4], imem.data[3:0]);
        w_icode_cur = (r_count == 4'd0) ? imem.data[7:4] : r_icode;
        // valC occupies bytes 1..8 of a 9-byte and bytes 2..9 of a
        // 10-byte instruction; the 3-bit subtraction wraps into 0..7.
        w_valc_byte = ((r_len == 4'd9)  && (r_count >= 4'd1)) ||
                      ((r_len == 4'd10) && (r_count >= 4'd2));
        w_valc_idx  = (r_len == 4'd9) ? (r_count[2:0] - 3'd1)
                                      : (r_count[2:0] - 3'd2);
        // Wraps modulo 2^64 so a fetch crossing the top continues at 0.
        w_addr      = r_pc + {60'd0, r_count};
        w_beat      = (r_state == S_FETCH) && imem.ack;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        imem.req    = 1'b0;
        imem.addr   = w_addr;
        case (r_state)
            S_FETCH: begin
                // Gated by the reset input so the request drops the
                // moment reset is asserted, without waiting for a clock.
                imem.req = i_rst_n;
                if (imem.ack) begin
                    if (imem.err || w_bad0) begin
                        w_state_nxt = S_HALT;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_pc_load) begin
                    if (r_stat == STAT_AOK) begin
                        w_state_nxt = S_FETCH;
                    end else if (r_stat == STAT_HLT) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    // PC, byte counter, decoded fields and status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_PC;
            r_count <= 4'd0;
            r_len   <= 4'd1;
            r_icode <= 4'h0;
            r_ifun  <= 4'h0;
            r_ra    <= REG_NONE;
            r_rb    <= REG_NONE;
            r_valc  <= 64'd0;
            r_valp  <= 64'd0;
            r_valid <= 1'b0;
            r_stat  <= STAT_AOK;
        end else if (w_beat) begin
            if (imem.err) begin
                r_stat  <= STAT_ADR;
                r_valid <= 1'b0;
            end else if (w_bad0) begin
                // Fields keep their previous values; only status changes.
                r_stat <= STAT_INS;
            end else begin
                r_count <= w_count_inc;
                if (r_count == 4'd0) begin
                    // Start of a new instruction: clear the optional
                    // fields so short instructions report F/F and valC=0.
                    r_icode <= imem.data[7:4];
                    r_ifun  <= imem.data[3:0];
                    r_ra    <= REG_NONE;
                    r_rb    <= REG_NONE;
                    r_valc  <= 64'd0;
                    r_len   <= w_len0;
                end else begin
                    if ((r_count == 4'd1) &&
                        ((r_len == 4'd2) || (r_len == 4'd10))) begin
                        r_ra <= imem.data[7:4];
                        r_rb <= imem.data[3:0];
                    end
                    if (w_valc_byte) begin
                        r_valc[{w_valc_idx, 3'b000} +: 8] <= imem.data;
                    end
                end
                if (w_last) begin
                    r_valid <= 1'b1;
                    r_valp  <= r_pc + {60'd0, w_len};
                    r_stat  <= (w_icode_cur == 4'h0) ? STAT_HLT : STAT_AOK;
                end
            end
        end else if ((r_state == S_DONE) && i_pc_load) begin
            if (r_stat == STAT_AOK) begin
                r_pc    <= i_pc_in;
                r_count <= 4'd0;
                r_valid <= 1'b0;
            end else if (r_stat == STAT_HLT) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_icode       = r_icode;
    assign o_ifun        = r_ifun;
    assign o_ra          = r_ra;
    assign o_rb          = r_rb;
    assign o_valc        = r_valc;
    assign o_valp        = r_valp;
    assign o_pc          = r_pc;
    assign o_instr_valid = r_valid;
    assign o_stat        = r_stat;

endmodule
